// File: rtl/fix2flt_sched_if.sv
// Request/response bundle for fix2flt_sched: NREQ fixed-point requesters in,
// one IEEE-754 single-precision result stream out.
interface fix2flt_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_data;
  logic [IDW-1:0]     rsp_id;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/fix2flt_sched.sv
// Round-robin scheduler feeding a one-cycle Q-format fixed -> float32 converter.
// Define FIX2FLT_SCHED_PERF_CNT_EN to add the perf_count completed-result counter.
module fix2flt_sched #(
  parameter int Q    = 16,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  fix2flt_sched_if.slave    bus,
`ifdef FIX2FLT_SCHED_PERF_CNT_EN
  output logic [15:0]       perf_count,
`endif
  output logic              busy
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [31:0]    op;
  logic [IDW-1:0] op_id;

  logic            opp;
  logic            hs;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic [31:0]     gdata;

  function automatic logic [31:0] to_float(input logic [31:0] v);
    logic [31:0] mag;
    logic [31:0] norm;
    logic [7:0]  expo;
    int          p;
    mag = v[31] ? (~v + 32'd1) : v;
    p = 0;
    for (int b = 0; b < 32; b++)
      if (mag[b]) p = b;
    // Put the leading one at bit 31; the 23 bits below it are the mantissa.
    norm = mag << (31 - p);
    expo = 8'(127 + p - Q);
    to_float = (mag == 32'd0) ? 32'd0 : {v[31], expo, norm[30:8]};
  endfunction

  // Reset gates the grant so nothing can be accepted while rst is held.
  assign opp = !rst && ((state == IDLE) || (state == RESP && bus.rsp_ready));

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    gidx  = '0;
    gdata = '0;
    hs    = 1'b0;
    if (opp) begin
      for (int k = 1; k <= NREQ; k++) begin
        j = (int'(ptr) + k) % NREQ;
        if (!hs && bus.req_valid[j]) begin
          hs       = 1'b1;
          grant[j] = 1'b1;
          gidx     = IDW'(j);
          gdata    = bus.req_data[32*j +: 32];
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= IDW'(NREQ - 1);
      op            <= '0;
      op_id         <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            op    <= gdata;
            op_id <= gidx;
            ptr   <= gidx;
            state <= CONV;
          end
        end
        CONV: begin
          bus.rsp_data  <= to_float(op);
          bus.rsp_id    <= op_id;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          // Completion and the next grant share this cycle for 1 result / 2 cycles.
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            if (hs) begin
              op    <= gdata;
              op_id <= gidx;
              ptr   <= gidx;
              state <= CONV;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIX2FLT_SCHED_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_count <= '0;
    else if (bus.rsp_valid && bus.rsp_ready)
      perf_count <= perf_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fix2flt_sched.sv
// Directed bench for fix2flt_sched (Q=16, NREQ=4): reset, conversion values,
// round-robin fairness, backpressure and mid-flight reset.
module tb_fix2flt_sched;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
`ifdef FIX2FLT_SCHED_PERF_CNT_EN
  logic [15:0] perf_count;
`endif
  int total = 0;
  int bad   = 0;

  fix2flt_sched_if #(.NREQ(NREQ)) bus();

  fix2flt_sched #(.Q(16), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
`ifdef FIX2FLT_SCHED_PERF_CNT_EN
    .perf_count (perf_count),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] v);
    bus.req_data[32*i +: 32] = v;
  endtask

  task automatic test_reset;
    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    #1 rst = 1'b1;
    tick;
    tick;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0h exp=0", bus.rsp_valid); end
    total++; if (bus.rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data got=%08h exp=00000000", bus.rsp_data); end
    total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); end
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    bus.req_valid = '0;
    rst = 1'b0;
    tick;
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL idle_no_valid_ready got=%b exp=0000", bus.req_ready); end
  endtask

  task automatic test_single;
    bus.rsp_ready = 1'b1;
    set_op(0, 32'h0001_0000);
    bus.req_valid = 4'b0001;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", bus.req_ready); end
    tick;
    bus.req_valid = '0;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_conv_valid got=%0h exp=0", bus.rsp_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_conv_busy got=%0h exp=1", busy); end
    tick;
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid got=%0h exp=1", bus.rsp_valid); end
    total++; if (bus.rsp_data !== 32'h3F80_0000) begin bad++; $display("FAIL single_rsp_data got=%08h exp=3f800000", bus.rsp_data); end
    total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL single_rsp_id got=%0d exp=0", bus.rsp_id); end
    tick;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_done_valid got=%0h exp=0", bus.rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_done_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_sweep;
    logic [31:0] vin [4];
    logic [31:0] vexp[4];
    vin  = '{32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_8000};
    vexp = '{32'hBF80_0000, 32'h0000_0000, 32'hC700_0000, 32'h3F00_0000};
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      set_op(2, vin[n]);
      bus.req_valid = 4'b0100;
      #1;
      total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL sweep%0d_grant got=%b exp=0100", n, bus.req_ready); end
      tick;
      bus.req_valid = '0;
      tick;
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL sweep%0d_valid got=%0h exp=1", n, bus.rsp_valid); end
      total++; if (bus.rsp_data !== vexp[n]) begin bad++; $display("FAIL sweep%0d_data got=%08h exp=%08h", n, bus.rsp_data, vexp[n]); end
      total++; if (bus.rsp_id !== 2'd2) begin bad++; $display("FAIL sweep%0d_id got=%0d exp=2", n, bus.rsp_id); end
      tick;
    end
  endtask

  task automatic test_fairness;
    logic [31:0] fexp[4];
    logic        ev;
    int          r;
    fexp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, (i + 1) << 16);
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL fair_first_grant got=%b exp=0001", bus.req_ready); end
    for (int t = 1; t <= 12; t++) begin
      tick;
      ev = (t % 2 == 0);
      total++; if (bus.rsp_valid !== ev) begin bad++; $display("FAIL fair_t%0d_valid got=%0h exp=%0h", t, bus.rsp_valid, ev); end
      if (ev) begin
        r = (t / 2 - 1) % 4;
        total++; if (bus.rsp_id !== 2'(r)) begin bad++; $display("FAIL fair_t%0d_id got=%0d exp=%0d", t, bus.rsp_id, r); end
        total++; if (bus.rsp_data !== fexp[r]) begin bad++; $display("FAIL fair_t%0d_data got=%08h exp=%08h", t, bus.rsp_data, fexp[r]); end
      end
      if (t == 12) bus.req_valid = '0;
    end
    tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fair_end_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_backpressure;
    // Last grant was requester 1; requester 0 is the only one asking now.
    set_op(0, 32'hFFFF_0000);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL bp_grant got=%b exp=0001", bus.req_ready); end
    tick;
    bus.req_valid = '1;
    tick;
    for (int k = 0; k < 5; k++) begin
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp%0d_valid got=%0h exp=1", k, bus.rsp_valid); end
      total++; if (bus.rsp_data !== 32'hBF80_0000) begin bad++; $display("FAIL bp%0d_data got=%08h exp=bf800000", k, bus.rsp_data); end
      total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL bp%0d_id got=%0d exp=0", k, bus.rsp_id); end
      #1;
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL bp%0d_ready got=%b exp=0000", k, bus.req_ready); end
      tick;
    end
    bus.rsp_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_grant got=%b exp=0010", bus.req_ready); end
    tick;
    bus.req_valid = '0;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_conv_valid got=%0h exp=0", bus.rsp_valid); end
    tick;
    total++; if (bus.rsp_id !== 2'd1) begin bad++; $display("FAIL bp_next_id got=%0d exp=1", bus.rsp_id); end
    total++; if (bus.rsp_data !== 32'h4000_0000) begin bad++; $display("FAIL bp_next_data got=%08h exp=40000000", bus.rsp_data); end
    tick;
  endtask

  task automatic test_reset_mid;
    bus.rsp_ready = 1'b1;
    set_op(2, 32'h0003_0000);
    bus.req_valid = 4'b0100;
    tick;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_conv_busy got=%0h exp=1", busy); end
    rst = 1'b1;
    #1;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0h exp=0", bus.rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0h exp=0", busy); end
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rmid_ready got=%b exp=0000", bus.req_ready); end
    bus.req_valid = '1;
    set_op(0, 32'h0005_0000);
    #1 rst = 1'b0;
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_first_grant got=%b exp=0001", bus.req_ready); end
    tick;
    bus.req_valid = '0;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_stale got=%0h exp=0", bus.rsp_valid); end
    tick;
    total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL rmid_rsp_id got=%0d exp=0", bus.rsp_id); end
    total++; if (bus.rsp_data !== 32'h40A0_0000) begin bad++; $display("FAIL rmid_rsp_data got=%08h exp=40a00000", bus.rsp_data); end
    tick;
  endtask

`ifdef FIX2FLT_SCHED_PERF_CNT_EN
  task automatic test_perf;
    rst = 1'b1;
    #1 rst = 1'b0;
    bus.rsp_ready = 1'b1;
    set_op(0, 32'h0001_0000);
    for (int n = 0; n < 10; n++) begin
      bus.req_valid = 4'b0001;
      tick;
      bus.req_valid = '0;
      tick;
      tick;
    end
    total++; if (perf_count !== 16'd10) begin bad++; $display("FAIL perf_ten got=%0d exp=10", perf_count); end
    force dut.perf_count = 16'hFFFF;
    #1 release dut.perf_count;
    bus.req_valid = 4'b0001;
    tick;
    bus.req_valid = '0;
    tick;
    tick;
    total++; if (perf_count !== 16'h0000) begin bad++; $display("FAIL perf_wrap got=%04h exp=0000", perf_count); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_sweep;
    test_fairness;
    test_backpressure;
    test_reset_mid;
`ifdef FIX2FLT_SCHED_PERF_CNT_EN
    test_perf;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fix2flt_sched.md
FIX2FLT_SCHED -- requirements
Module: fix2flt_sched

Interface
REQ-001 Parameter Q, default 16: fractional bits of the signed 32-bit fixed-point operand.
REQ-002 Parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester operand-valid.
REQ-006 req_ready  output  NREQ  per-requester grant/accept, at most one bit high.
REQ-007 req_data  input  32*NREQ  operands; requester i at bits [32i+31:32i], two's complement Q-format.
REQ-008 rsp_valid  output  1  result valid.
REQ-009 rsp_ready  input  1  downstream accepts result.
REQ-010 rsp_data  output  32  IEEE-754 single-precision result.
REQ-011 rsp_id  output  clog2(NREQ)  index of the requester that owns rsp_data.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 perf_count  output  16  completed-conversion count; present only when the configuration macro is defined.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, CONV and RESP.
REQ-015 A grant opportunity SHALL exist in IDLE, and in RESP when rsp_ready=1.
REQ-016 At a grant opportunity with any req_valid high, req_ready SHALL be high combinationally for exactly one requester, chosen round-robin starting at the index after the last granted one; all other bits SHALL be 0.
REQ-017 On a handshake (req_valid[i] & req_ready[i]), the block SHALL capture the operand and i, and go to CONV.
REQ-018 A RESP-state completion (rsp_ready=1) with no req_valid high SHALL go to IDLE.
REQ-019 CONV SHALL last one cycle, register the converted result into rsp_data/rsp_id, then go to RESP.
REQ-020 rsp_valid SHALL be high exactly in RESP.
REQ-021 Latency: a handshake in cycle c SHALL produce rsp_valid=1 in cycle c+2.
REQ-022 Sustained throughput SHALL be one result per 2 cycles.
REQ-023 While rsp_valid=1 and rsp_ready=0, rsp_data and rsp_id SHALL hold stable and req_ready SHALL be all zero.
REQ-024 Conversion operand handling:
- sign = operand bit 31;
- magnitude = two's-complement absolute value, 32-bit unsigned, so 0x80000000 gives magnitude 2^31.
REQ-025 Conversion exponent and mantissa:
- p = index of the leading one of the magnitude;
- exponent = 127 + p - Q, 8-bit;
- mantissa = the 23 bits immediately below the leading one, truncated and zero-padded on the right.
REQ-026 A zero operand SHALL produce 0x00000000.
REQ-027 No rounding, denormal, overflow or underflow handling SHALL exist; for Q in 0..31 the exponent cannot leave range.
REQ-028 A requester deasserting req_valid without a handshake SHALL be legal; the grant re-evaluates every cycle.

Reset
REQ-029 rst=1 SHALL immediately force:
- state = IDLE;
- rsp_valid = 0, rsp_data = 0, rsp_id = 0;
- req_ready = all zero;
- round-robin pointer = NREQ-1, so requester 0 has first priority;
- perf_count = 0.
REQ-030 Reset during CONV or RESP SHALL discard the in-flight conversion without producing a response.

Configuration
REQ-031 Macro FIX2FLT_SCHED_PERF_CNT_EN defined: perf_count exists and increments by 1 on each rsp_valid & rsp_ready cycle, wrapping 0xFFFF to 0x0000.
REQ-032 FIX2FLT_SCHED_PERF_CNT_EN undefined: neither the perf_count port nor its counter logic exists; all other behaviour is identical.

Verification
REQ-033 Single request: req_valid[0]=1, data 0x00010000, Q=16, rsp_ready=1 -> handshake cycle c; cycle c+2: rsp_valid=1, rsp_data 0x3F800000, rsp_id 0.
REQ-034 Value sweep on requester 2, Q=16:
- 0xFFFF0000 -> 0xBF800000;
- 0x00000000 -> 0x00000000;
- 0x80000000 -> 0xC7000000;
- 0x00008000 -> 0x3F000000;
- each with rsp_id=2.
REQ-035 Fairness: all four req_valid held high, rsp_ready=1 -> response ids 0,1,2,3,0,1 with rsp_valid high every second cycle.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_data/rsp_id unchanged, req_ready all zero; rsp_ready=1 -> next grant in that same cycle.
REQ-037 Reset mid-operation: rst pulsed while in CONV -> rsp_valid=0 immediately, no response emitted; with req_valid=4'b1111 afterwards, first grant goes to requester 0.
REQ-038 Macro defined: 10 accepted results -> perf_count=10; preload the counter to 0xFFFF plus 1 result -> 0x0000.
